i2c_bit_ctrl: RTL and testbench
===============================

# i2c_bit_ctrl

Bit-level I2C master sequencer that sits between the byte-level command controller and the open-drain SCL/SDA pads. It accepts one bus primitive at a time (START, STOP, WRITE bit, READ bit). It times every primitive as four equal phases, each phase being one divided SCL quarter-period set by `div_cnt`. It freezes timing while a slave stretches SCL and reports arbitration loss on written ones.

## Interface
- No parameters; divider width fixed at 11 bits.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `div_cnt`  in  11  quarter-period length minus one; latched at command acceptance.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high when idle; command accepted on `cmd_valid && cmd_ready`.
- `cmd`  in  3  1=START, 2=STOP, 3=WRITE, 4=READ; other codes are NOP.
- `din`  in  1  bit to write; latched at acceptance.
- `dout`  out  1  bit sampled by READ; holds until the next READ completes.
- `done`  out  1  one-cycle pulse when a command completes normally.
- `al`  out  1  one-cycle arbitration-lost pulse.
- `busy`  out  1  high while a command is in progress.
- `scl_i`, `sda_i`  in  1 each  synchronized pad inputs.
- `scl_oe`, `sda_oe`  out  1 each  1 = drive line low, 0 = release.

## Operation
- FSM states: IDLE, PH_A, PH_B, PH_C, PH_D.
- IDLE: `cmd_ready`=1, `busy`=0.
- Acceptance latches `cmd`, `din` and `div_cnt`, then moves to PH_A with the phase counter at 0.
- Each phase lasts until the counter reaches the latched `div_cnt`. The counter then resets to 0 and the FSM advances.
- After PH_D, the FSM returns to IDLE and pulses `done`.
- Line drive per phase, listed as A/B/C/D. "rel" means oe=0; "low" means oe=1.
  - START: SDA rel/rel/low/low; SCL low/rel/rel/low. This also serves as a repeated START from SCL-low.
  - STOP: SDA low/low/low/rel; SCL low/rel/rel/rel.
  - WRITE: SDA = `din` in all phases (1 → rel, 0 → low); SCL low/rel/rel/low.
  - READ: SDA rel in all phases; SCL low/rel/rel/low. `dout` takes `sda_i` on the last cycle of PH_C.
- NOP codes: accepted, no line change, `done` pulses the cycle after acceptance.
- Clock stretching: in any phase where this block releases SCL and `scl_i`=0, the phase counter holds. The phase does not advance until `scl_i` is seen high.
- Arbitration:
  - Condition: during WRITE with `din`=1, `sda_i`=0 is sampled on any cycle of PH_B or PH_C while SCL is not stretched.
  - Response: `al` pulses and both oe lines release in the following cycle. The FSM returns to IDLE and `done` is not asserted.
- `div_cnt` changes while busy have no effect until the next acceptance.

## Timing
- Reset values: `scl_oe`=0, `sda_oe`=0, `done`=0, `al`=0, `dout`=0, `busy`=0, `cmd_ready`=1, FSM=IDLE.
- Reset asserted mid-command releases both lines immediately (asynchronous) and discards the command.
- Phase A drive values appear on the first rising edge after acceptance.
- Without stretching, each phase lasts `div_cnt`+1 cycles. Phase D ends 4×(`div_cnt`+1) cycles after acceptance.
- `done` is high on the next cycle. `cmd_ready` returns high in that same cycle, so back-to-back acceptance is possible with one idle cycle.
- `div_cnt`=0 is legal: each phase is 1 cycle and a command takes 4 cycles plus the `done` cycle.
- Stretch cycles add exactly one cycle each to the affected phase.
- `al` and `done` are never high together.
- `cmd_valid` while busy is ignored: `cmd_ready`=0 and nothing is latched.

## Test plan
- Reset check: assert `rst` low, release, apply no commands → all outputs at reset values; `scl_oe`=`sda_oe`=0 indefinitely.
- WRITE bit with `div_cnt`=3, `din`=0, no stretch → SDA low for 16 cycles; SCL low 4 / rel 8 / low 4; `done` on cycle 17 after acceptance.
- Byte transfer, `div_cnt`=2:
  - Stimulus: START, READ with `sda_i`=1, READ with `sda_i`=0, STOP.
  - Required: `dout`=1, then `dout`=0; phase sequences match the Operation list; STOP leaves both lines released.
- Stretch during WRITE, `div_cnt`=4: hold `scl_i`=0 for 10 cycles from the start of PH_B → `done` arrives exactly 10 cycles later than the unstretched count of 21.
- Arbitration loss: WRITE `din`=1 with `sda_i` forced 0 in PH_B → `al` single pulse, oe lines both 0 next cycle, no `done`, `cmd_ready`=1.
- Robustness, two parts:
  - NOP code 7 → `done` the cycle after acceptance, no line activity.
  - Reset asserted during PH_C of READ → immediate release of both lines, IDLE after reset.

Source files
------------

// File: rtl/i2c_bit_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bit_ctrl_if
// Brief    : Command handshake and open-drain pad bundle for i2c_bit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_bit_ctrl_if;
    logic [10:0] div_cnt;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd;
    logic        din;
    logic        dout;
    logic        done;
    logic        al;
    logic        busy;
    logic        scl_i;
    logic        sda_i;
    logic        scl_oe;
    logic        sda_oe;

    modport slave (
        input  div_cnt, cmd_valid, cmd, din, scl_i, sda_i,
        output cmd_ready, dout, done, al, busy, scl_oe, sda_oe
    );

    modport master (
        output div_cnt, cmd_valid, cmd, din, scl_i, sda_i,
        input  cmd_ready, dout, done, al, busy, scl_oe, sda_oe
    );
endinterface
`default_nettype wire

// File: rtl/i2c_bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bit_ctrl
// Brief    : Bit-level I2C master sequencer (START/STOP/WRITE/READ, 4 phases).
// Revision : 1.0 - initial release
// ============================================================================
module i2c_bit_ctrl (
    input  wire logic      clk,
    input  wire logic      rst,
    i2c_bit_ctrl_if.slave  bus
);
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_PH_A = 3'd1;
    localparam logic [2:0] c_ST_PH_B = 3'd2;
    localparam logic [2:0] c_ST_PH_C = 3'd3;
    localparam logic [2:0] c_ST_PH_D = 3'd4;

    localparam logic [2:0] c_CMD_START = 3'd1;
    localparam logic [2:0] c_CMD_STOP  = 3'd2;
    localparam logic [2:0] c_CMD_WRITE = 3'd3;
    localparam logic [2:0] c_CMD_READ  = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [10:0] r_cnt;
    logic [10:0] r_div;
    logic [2:0]  r_cmd;
    logic        r_din;
    logic        r_dout;
    logic        r_done;
    logic        r_al;
    logic        w_scl_oe;
    logic        w_sda_oe;
    logic        w_accept;
    logic        w_valid_code;
    logic        w_busy;
    logic        w_stretch;
    logic        w_phase_end;
    logic        w_arb_lost;

    assign w_busy       = (r_state != c_ST_IDLE);
    assign w_accept     = bus.cmd_valid && !w_busy;
    assign w_valid_code = (bus.cmd >= c_CMD_START) && (bus.cmd <= c_CMD_READ);
    // A slave holding a released SCL low freezes the phase timer.
    assign w_stretch    = w_busy && !w_scl_oe && !bus.scl_i;
    assign w_phase_end  = (r_cnt == r_div) && !w_stretch;
    assign w_arb_lost   = ((r_state == c_ST_PH_B) || (r_state == c_ST_PH_C)) &&
                          (r_cmd == c_CMD_WRITE) && r_din && !w_stretch && !bus.sda_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept && w_valid_code) w_next_state = c_ST_PH_A;
            c_ST_PH_A: if (w_phase_end) w_next_state = c_ST_PH_B;
            c_ST_PH_B: begin
                if (w_arb_lost)       w_next_state = c_ST_IDLE;
                else if (w_phase_end) w_next_state = c_ST_PH_C;
            end
            c_ST_PH_C: begin
                if (w_arb_lost)       w_next_state = c_ST_IDLE;
                else if (w_phase_end) w_next_state = c_ST_PH_D;
            end
            c_ST_PH_D: if (w_phase_end) w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Line drive is a pure function of state and the latched command, so an
    // asynchronous reset releases both lines at once.
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        if (w_busy) begin
            w_scl_oe = (r_state == c_ST_PH_A) ||
                       ((r_state == c_ST_PH_D) && (r_cmd != c_CMD_STOP));
            case (r_cmd)
                c_CMD_START: w_sda_oe = (r_state == c_ST_PH_C) || (r_state == c_ST_PH_D);
                c_CMD_STOP:  w_sda_oe = (r_state != c_ST_PH_D);
                c_CMD_WRITE: w_sda_oe = !r_din;
                default:     w_sda_oe = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 11'd0;
            r_div  <= 11'd0;
            r_cmd  <= 3'd0;
            r_din  <= 1'b0;
            r_dout <= 1'b0;
            r_done <= 1'b0;
            r_al   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_al   <= 1'b0;
            if (w_accept) begin
                r_cmd  <= bus.cmd;
                r_din  <= bus.din;
                r_div  <= bus.div_cnt;
                r_cnt  <= 11'd0;
                r_done <= !w_valid_code;
            end else if (w_busy) begin
                if (w_arb_lost) begin
                    r_al  <= 1'b1;
                    r_cnt <= 11'd0;
                end else if (w_phase_end) begin
                    r_cnt <= 11'd0;
                    if (r_state == c_ST_PH_D)
                        r_done <= 1'b1;
                    if ((r_state == c_ST_PH_C) && (r_cmd == c_CMD_READ))
                        r_dout <= bus.sda_i;
                end else if (!w_stretch) begin
                    r_cnt <= r_cnt + 11'd1;
                end
            end
        end
    end

    assign bus.cmd_ready = !w_busy;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.al        = r_al;
    assign bus.dout      = r_dout;
    assign bus.scl_oe    = w_scl_oe;
    assign bus.sda_oe    = w_sda_oe;
endmodule
`default_nettype wire

// File: tb/tb_i2c_bit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_bit_ctrl
// Brief    : Directed self-checking bench for i2c_bit_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bit_ctrl;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    i2c_bit_ctrl_if bif ();

    i2c_bit_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one cycle, then scramble div_cnt to prove it was latched.
    task automatic issue(input logic [2:0] c, input logic d, input logic [10:0] div);
        bif.cmd_valid = 1'b1;
        bif.cmd       = c;
        bif.din       = d;
        bif.div_cnt   = div;
        chk("issue_ready", {31'd0, bif.cmd_ready}, 32'd1);
        tick();
        bif.cmd_valid = 1'b0;
        bif.cmd       = 3'd0;
        bif.div_cnt   = 11'd7;
    endtask

    // Patterns: bit3 = phase A ... bit0 = phase D; 1 = line driven low.
    task automatic run_cmd(input string tag, input logic [2:0] c, input logic d,
                           input int div, input logic [3:0] sda_pat, input logic [3:0] scl_pat);
        int ph;
        issue(c, d, 11'(div));
        for (int n = 1; n <= 4 * (div + 1); n++) begin
            ph = (n - 1) / (div + 1);
            chk($sformatf("%s_sda_c%0d", tag, n), {31'd0, bif.sda_oe}, {31'd0, sda_pat[3-ph]});
            chk($sformatf("%s_scl_c%0d", tag, n), {31'd0, bif.scl_oe}, {31'd0, scl_pat[3-ph]});
            chk($sformatf("%s_done_c%0d", tag, n), {31'd0, bif.done}, 32'd0);
            tick();
        end
        chk({tag, "_done"}, {31'd0, bif.done}, 32'd1);
        chk({tag, "_al"}, {31'd0, bif.al}, 32'd0);
        chk({tag, "_ready"}, {31'd0, bif.cmd_ready}, 32'd1);
    endtask

    initial begin
        int done_at;
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bif.cmd_valid = 1'b0;
        bif.cmd       = 3'd0;
        bif.din       = 1'b0;
        bif.div_cnt   = 11'd0;
        bif.scl_i     = 1'b1;
        bif.sda_i     = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Reset state, held idle
        chk("rst_ready", {31'd0, bif.cmd_ready}, 32'd1);
        chk("rst_busy",  {31'd0, bif.busy}, 32'd0);
        chk("rst_done",  {31'd0, bif.done}, 32'd0);
        chk("rst_al",    {31'd0, bif.al}, 32'd0);
        chk("rst_dout",  {31'd0, bif.dout}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("rst_oe", {30'd0, bif.scl_oe, bif.sda_oe}, 32'd0);
            tick();
        end

        // Single write bit, and the div_cnt=0 boundary
        run_cmd("wr0_d3", 3'd3, 1'b0, 3, 4'b1111, 4'b1001);
        run_cmd("wr1_d0", 3'd3, 1'b1, 0, 4'b0000, 4'b1001);

        // START, READ 1, READ 0, STOP back to back
        run_cmd("start", 3'd1, 1'b0, 2, 4'b0011, 4'b1001);
        bif.sda_i = 1'b1;
        run_cmd("rd1", 3'd4, 1'b0, 2, 4'b0000, 4'b1001);
        chk("rd1_dout", {31'd0, bif.dout}, 32'd1);
        bif.sda_i = 1'b0;
        run_cmd("rd0", 3'd4, 1'b0, 2, 4'b0000, 4'b1001);
        chk("rd0_dout", {31'd0, bif.dout}, 32'd0);
        bif.sda_i = 1'b1;
        run_cmd("stop", 3'd2, 1'b0, 2, 4'b1110, 4'b1000);
        chk("stop_oe", {30'd0, bif.scl_oe, bif.sda_oe}, 32'd0);
        chk("stop_dout_hold", {31'd0, bif.dout}, 32'd0);
        tick();

        // Clock stretch: 10 cycles from start of PH_B -> done at 21 + 10
        issue(3'd3, 1'b0, 11'd4);
        done_at = 0;
        for (int n = 1; n <= 60 && done_at == 0; n++) begin
            bif.scl_i = (n >= 6 && n <= 15) ? 1'b0 : 1'b1;
            if (bif.done) done_at = n;
            else tick();
        end
        bif.scl_i = 1'b1;
        chk("stretch_done_cycle", 32'(done_at), 32'd31);
        tick();

        // Arbitration loss in PH_B
        issue(3'd3, 1'b1, 11'd2);
        tick(); tick(); tick();
        chk("arb_in_phb_scl", {31'd0, bif.scl_oe}, 32'd0);
        bif.sda_i = 1'b0;
        tick();
        bif.sda_i = 1'b1;
        chk("arb_al",    {31'd0, bif.al}, 32'd1);
        chk("arb_oe",    {30'd0, bif.scl_oe, bif.sda_oe}, 32'd0);
        chk("arb_done",  {31'd0, bif.done}, 32'd0);
        chk("arb_ready", {31'd0, bif.cmd_ready}, 32'd1);
        tick();
        chk("arb_al_once",  {31'd0, bif.al}, 32'd0);
        chk("arb_no_done",  {31'd0, bif.done}, 32'd0);
        tick();

        // NOP code
        issue(3'd7, 1'b0, 11'd3);
        chk("nop_done", {31'd0, bif.done}, 32'd1);
        chk("nop_busy", {31'd0, bif.busy}, 32'd0);
        chk("nop_oe",   {30'd0, bif.scl_oe, bif.sda_oe}, 32'd0);
        tick();
        chk("nop_done_once", {31'd0, bif.done}, 32'd0);

        // Busy command ignored: timing of running WRITE unchanged
        issue(3'd3, 1'b0, 11'd1);
        bif.cmd_valid = 1'b1;
        bif.cmd       = 3'd1;
        chk("busy_ready", {31'd0, bif.cmd_ready}, 32'd0);
        repeat (7) tick();
        chk("busy_wr_sda", {31'd0, bif.sda_oe}, 32'd1);
        bif.cmd_valid = 1'b0;
        tick();
        chk("busy_wr_done", {31'd0, bif.done}, 32'd1);
        tick();

        // Reset during PH_C of READ
        issue(3'd4, 1'b0, 11'd3);
        repeat (9) tick();
        chk("rstc_busy_pre", {31'd0, bif.busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstc_busy",  {31'd0, bif.busy}, 32'd0);
        chk("rstc_oe",    {30'd0, bif.scl_oe, bif.sda_oe}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rstc_ready", {31'd0, bif.cmd_ready}, 32'd1);
        chk("rstc_done",  {31'd0, bif.done}, 32'd0);

        // Reset during a driven WRITE 0 releases SDA asynchronously
        issue(3'd3, 1'b0, 11'd3);
        repeat (5) tick();
        chk("rstw_sda_pre", {31'd0, bif.sda_oe}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rstw_oe", {30'd0, bif.scl_oe, bif.sda_oe}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
